sequencer_engine: RTL
=====================

# sequencer_engine

Multi-track step sequencer core that generalises the single 16-beat pitch register of the first build. It holds a NUM_TRACKS × NUM_STEPS pitch grid and accepts single-step edits from the button-matrix/rotary-encoder front end. It runs a play/stop transport with a programmable step period and loop length, and presents the current step's pitch and gate for every track to the audio controller.

## Interface
Parameters:
- NUM_STEPS, 16, steps per pattern (≥2)
- NUM_TRACKS, 4, independent pitch tracks (≥1)
- PITCH_W, 4, pitch code width; code 0 = rest
- PERIOD_W, 24, width of step_period (12 MHz × 1 s fits)

Ports (STEP_W = $clog2(NUM_STEPS), TRK_W = max(1, $clog2(NUM_TRACKS))):
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- edit_valid  in  1  write edit_pitch into grid[edit_track][edit_step] this cycle
- edit_track  in  TRK_W  track to write
- edit_step  in  STEP_W  step to write
- edit_pitch  in  PITCH_W  pitch to store (0 clears the step)
- play  in  1  single-cycle start/resume request
- stop  in  1  single-cycle stop request
- step_period  in  PERIOD_W  clock cycles per step
- loop_len  in  STEP_W+1  active pattern length
- running  out  1  transport is in RUN
- step_idx  out  STEP_W  current step
- step_pulse  out  1  one-cycle strobe when a step begins
- pitch_out  out  NUM_TRACKS*PITCH_W  grid[t][step_idx]; track t at bits [t*PITCH_W +: PITCH_W]
- gate_out  out  NUM_TRACKS  per-track note gate

## Operation
- Grid: NUM_TRACKS*NUM_STEPS registers of PITCH_W bits, all 0 after reset. An edit is written at the clock edge. Out-of-range edit_track or edit_step values are ignored.
- Effective period: P = max(step_period, 2). Effective length: L = NUM_STEPS if loop_len==0 or loop_len>NUM_STEPS, else loop_len.
- FSM states: STOP and RUN. Reset enters STOP with step_idx=0 and phase counter cnt=0.
  - STOP, play → RUN. step_idx is kept (resume), cnt is cleared, and step_pulse fires.
  - RUN, stop → STOP. step_idx and cnt freeze.
  - STOP, stop → step_idx=0 (a second stop rewinds).
  - play and stop in the same cycle: stop wins.
  - play in RUN is ignored.
- Phase counter: in RUN, cnt increments every cycle. When cnt ≥ P−1 (≥ so that a mid-step period decrease terminates cleanly):
  - cnt ← 0
  - step_idx ← (step_idx+1 ≥ L) ? 0 : step_idx+1
  - step_pulse fires
- If loop_len shrinks below the current step, the next advance wraps to 0.
- pitch_out is combinational from the registered grid and step_idx. It is valid in STOP as well, so the front end can preview the step.
- gate_out[t] = running && grid[t][step_idx]≠0 && cnt < (P>>1), giving a 50% duty gate that rounds down.
- Live edit of the playing step shows on pitch_out and gate_out the cycle after edit_valid.
- Edit and advance in the same cycle: the edit is written, and the advance uses the old step_idx.

## Timing
- Reset values: running=0, step_idx=0, step_pulse=0, pitch_out=0, gate_out=0, grid=0, cnt=0.
- play sampled at edge T:
  - running=1, step_pulse=1, cnt=0 in cycle T+1.
  - The first advance occurs at edge T+P; the new step_idx and step_pulse are visible in cycle T+P+1.
- step_pulse is registered and lasts exactly one cycle, coincident with the new step_idx. Steady state gives one pulse per P cycles.
- stop sampled at edge T: running=0 and gate_out=0 in cycle T+1. There is no pulse.
- step_period and loop_len are sampled live every cycle. There is no shadow register.
- rst asserted mid-RUN: every state resets at the next edge, and rst has priority over play, stop and edit.

## Test plan
- Reset, then write track 1 step 3 = 5 and play with step_period=4, loop_len=0 → step_idx 0,1,2,3 every 4 cycles. In step 3, pitch_out[7:4]=5 and gate_out[1] is high for 2 cycles then low. step_pulse appears once per 4 cycles.
- loop_len=3, step_period=2, run 8 steps → step_idx sequence 0,1,2,0,1,2,0,1. Set loop_len=1 while at step 2 → the next step is 0, and step_idx stays 0 thereafter.
- Stop at step 5, wait 10 cycles, then play → resume at step 5 with cnt=0 and step_pulse set. Stop, stop → step_idx=0, running=0.
- play and stop in the same cycle from STOP → stays in STOP with no step_pulse. step_period=0 and 1 → the step advances every 2 cycles.
- Edit the current step (track 0, pitch 9) while RUN at cnt=1 → pitch_out[3:0]=9 the next cycle. Edit the same step to pitch 0 → gate_out[0]=0 the next cycle.
- Assert rst mid-step at step 7 → the next cycle shows running=0, step_idx=0, and the grid reads all 0.

Source files
------------

// File: rtl/sequencer_engine.sv
// sequencer_engine
// Multi-track step sequencer core. Holds a NUM_TRACKS x NUM_STEPS pitch grid
// that the front end edits one cell at a time. It runs a play/stop transport
// with a live step period and loop length, and presents the current step's
// pitch and gate for every track.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_edit_valid          write i_edit_pitch into grid[i_edit_track][i_edit_step]
//   i_edit_track/step     target cell (out-of-range values are ignored)
//   i_edit_pitch          pitch code, 0 = rest
//   i_play, i_stop        single-cycle transport requests (stop wins)
//   i_step_period         clock cycles per step (values below 2 act as 2)
//   i_loop_len            active pattern length (0 or > NUM_STEPS = full)
//   o_running             transport is running
//   o_step_idx            current step
//   o_step_pulse          one-cycle strobe when a step begins
//   o_pitch_out           grid[t][step] for track t at [t*PITCH_W +: PITCH_W]
//   o_gate_out            per-track 50% duty note gate
module sequencer_engine #(
  parameter int NUM_STEPS  = 16,
  parameter int NUM_TRACKS = 4,
  parameter int PITCH_W    = 4,
  parameter int PERIOD_W   = 24,
  localparam int STEP_W    = $clog2(NUM_STEPS),
  localparam int TRK_W     = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_edit_valid,
  input  logic [TRK_W-1:0]              i_edit_track,
  input  logic [STEP_W-1:0]             i_edit_step,
  input  logic [PITCH_W-1:0]            i_edit_pitch,
  input  logic                          i_play,
  input  logic                          i_stop,
  input  logic [PERIOD_W-1:0]           i_step_period,
  input  logic [STEP_W:0]               i_loop_len,
  output logic                          o_running,
  output logic [STEP_W-1:0]             o_step_idx,
  output logic                          o_step_pulse,
  output logic [NUM_TRACKS*PITCH_W-1:0] o_pitch_out,
  output logic [NUM_TRACKS-1:0]         o_gate_out
);

  typedef enum logic {S_STOP, S_RUN} state_t;

  state_t              r_state, w_state_next;
  logic [STEP_W-1:0]   r_step, w_step_next;
  logic [PERIOD_W-1:0] r_cnt, w_cnt_next;
  logic                r_pulse, w_pulse_next;
  logic [PITCH_W-1:0]  r_grid [NUM_TRACKS][NUM_STEPS];

  logic [PERIOD_W-1:0] w_period;
  logic [STEP_W:0]     w_len;
  logic [STEP_W:0]     w_step_inc;
  logic [STEP_W-1:0]   w_step_adv;
  logic                w_terminal;
  logic                w_edit_ok;

  // Clamp the live controls: a period under 2 would leave no room for the
  // gate-low half, and a zero or oversized length means "use the whole pattern".
  assign w_period = (i_step_period < PERIOD_W'(2)) ? PERIOD_W'(2) : i_step_period;
  assign w_len    = (i_loop_len == '0 || i_loop_len > (STEP_W+1)'(NUM_STEPS))
                    ? (STEP_W+1)'(NUM_STEPS) : i_loop_len;

  // Using >= rather than == makes a shrunken length or period take effect at
  // the very next advance instead of running the counter/step off the end.
  assign w_step_inc = {1'b0, r_step} + (STEP_W+1)'(1);
  assign w_step_adv = (w_step_inc >= w_len) ? '0 : w_step_inc[STEP_W-1:0];
  assign w_terminal = (r_cnt >= (w_period - PERIOD_W'(1)));

  assign w_edit_ok = (32'(i_edit_track) < NUM_TRACKS) && (32'(i_edit_step) < NUM_STEPS);

  // Transport next-state logic. Stop always beats play; a stop while already
  // stopped rewinds to step 0, and play resumes from the held step.
  always_comb begin
    w_state_next = r_state;
    w_step_next  = r_step;
    w_cnt_next   = r_cnt;
    w_pulse_next = 1'b0;
    case (r_state)
      S_STOP: begin
        if (i_stop) begin
          w_step_next = '0;
        end else if (i_play) begin
          w_state_next = S_RUN;
          w_cnt_next   = '0;
          w_pulse_next = 1'b1;
        end
      end
      S_RUN: begin
        if (i_stop) begin
          w_state_next = S_STOP;
        end else if (w_terminal) begin
          w_cnt_next   = '0;
          w_step_next  = w_step_adv;
          w_pulse_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + PERIOD_W'(1);
        end
      end
      default: w_state_next = S_STOP;
    endcase
  end

  // Transport registers; reset takes priority over every request.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_STOP;
      r_step  <= '0;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_step  <= w_step_next;
      r_cnt   <= w_cnt_next;
      r_pulse <= w_pulse_next;
    end
  end

  // Pitch grid. Edits land independently of the transport, so an edit and an
  // advance in the same cycle both take effect.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int t = 0; t < NUM_TRACKS; t++) begin
        for (int s = 0; s < NUM_STEPS; s++) begin
          r_grid[t][s] <= '0;
        end
      end
    end else if (i_edit_valid && w_edit_ok) begin
      r_grid[i_edit_track][i_edit_step] <= i_edit_pitch;
    end
  end

  // Outputs read the registered grid directly so the front end can preview a
  // step while stopped and see live edits one cycle later.
  always_comb begin
    o_pitch_out = '0;
    o_gate_out  = '0;
    for (int t = 0; t < NUM_TRACKS; t++) begin
      o_pitch_out[t*PITCH_W +: PITCH_W] = r_grid[t][r_step];
      o_gate_out[t] = (r_state == S_RUN) && (r_grid[t][r_step] != '0) &&
                      (r_cnt < (w_period >> 1));
    end
  end

  assign o_running    = (r_state == S_RUN);
  assign o_step_idx   = r_step;
  assign o_step_pulse = r_pulse;

endmodule
